// File: rtl/ai_result_stabilizer.sv
// Debounces raw AI classifier results: circular history of confident results,
// sequential majority vote with hysteresis, lock/change/timeout indications.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | cleared, waiting for the first enabled cycle
// S_FILL   | history not yet full, accepted results appended
// S_TRACK  | history full, next accepted (or pending) result starts a vote
// S_VOTE   | scanning one history entry per cycle into per-type counters
// S_DECIDE | winner selected, outputs and pulses registered
module ai_result_stabilizer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned VOTE_MIN       = 5,
    parameter logic [7:0]  CONF_MIN       = 8'd128,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ai_enable,
    input  logic [2:0] waveform_type_in,
    input  logic [7:0] confidence_in,
    input  logic       result_valid_in,
    output logic [2:0] stable_type,
    output logic [7:0] stable_confidence,
    output logic       locked,
    output logic       stable_valid,
    output logic       type_changed,
    output logic [7:0] dropped_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_TRACK  = 3'd2,
        S_VOTE   = 3'd3,
        S_DECIDE = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      hist_q [DEPTH];
    logic            wr_en;
    logic [2:0]      wr_data;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [PW-1:0]   scan_q, scan_d;
    logic [CW-1:0]   cnt_q [8];
    logic [CW-1:0]   cnt_d [8];
    logic            pend_vld_q, pend_vld_d;
    logic [2:0]      pend_type_q, pend_type_d;
    logic [2:0]      stype_q, stype_d;
    logic [7:0]      sconf_q, sconf_d;
    logic            locked_q, locked_d;
    logic            svalid_q, svalid_d;
    logic            tchg_q, tchg_d;
    logic [7:0]      drop_q, drop_d;
    logic [31:0]     tmo_q, tmo_d;

    logic            accept;
    logic            tmo_fire;
    logic [2:0]      win_type;
    logic [CW-1:0]   win_cnt;
    logic [15:0]     agree_w;
    logic [7:0]      agree;

    assign accept   = result_valid_in && ai_enable && (confidence_in >= CONF_MIN);
    assign tmo_fire = !result_valid_in && (tmo_q == TIMEOUT_CYCLES - 32'd1);

    // Strictly-greater scan from type 0 upward gives ties to the lowest code.
    always_comb begin
        win_type = 3'd0;
        win_cnt  = cnt_q[0];
        for (int t = 1; t < 8; t++) begin
            if (cnt_q[t] > win_cnt) begin
                win_cnt  = cnt_q[t];
                win_type = 3'(t);
            end
        end
        agree_w = (16'(win_cnt) * 16'd255) >> PW;
        agree   = (agree_w > 16'd255) ? 8'hFF : agree_w[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ai_enable) begin
            state_d = S_IDLE;
        end else if (tmo_fire && state_q != S_IDLE) begin
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_FILL;
                S_FILL:   if (accept && fill_q == CW'(DEPTH - 1)) state_d = S_VOTE;
                S_TRACK:  if (accept || pend_vld_q) state_d = S_VOTE;
                S_VOTE:   if (scan_q == PW'(DEPTH - 1)) state_d = S_DECIDE;
                S_DECIDE: state_d = S_TRACK;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        scan_d      = scan_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_type_d = pend_type_q;
        stype_d     = stype_q;
        sconf_d     = sconf_q;
        locked_d    = locked_q;
        drop_d      = drop_q;
        tmo_d       = tmo_q;
        svalid_d    = 1'b0;
        tchg_d      = 1'b0;
        wr_en       = 1'b0;
        wr_data     = waveform_type_in;

        if (!ai_enable) begin
            wptr_d      = '0;
            fill_d      = '0;
            scan_d      = '0;
            cnt_d       = '{default: '0};
            pend_vld_d  = 1'b0;
            pend_type_d = 3'd0;
            stype_d     = 3'd7;
            sconf_d     = 8'd0;
            locked_d    = 1'b0;
            drop_d      = 8'd0;
            tmo_d       = '0;
        end else begin
            if (result_valid_in) begin
                tmo_d = '0;
            end else if (tmo_q != TIMEOUT_CYCLES) begin
                tmo_d = tmo_q + 32'd1;
            end

            if (tmo_fire && state_q != S_IDLE) begin
                fill_d     = '0;
                wptr_d     = '0;
                pend_vld_d = 1'b0;
                stype_d    = 3'd7;
                locked_d   = 1'b0;
                tchg_d     = (stype_q != 3'd7);
            end else begin
                case (state_q)
                    S_FILL: begin
                        if (accept) begin
                            wr_en  = 1'b1;
                            wptr_d = wptr_q + PW'(1);
                            fill_d = fill_q + CW'(1);
                        end
                    end
                    // A held pending entry is consumed here, so chained votes sit DEPTH+2 apart.
                    S_TRACK: begin
                        if (pend_vld_q) begin
                            wr_en       = 1'b1;
                            wr_data     = pend_type_q;
                            wptr_d      = wptr_q + PW'(1);
                            pend_vld_d  = accept;
                            pend_type_d = waveform_type_in;
                        end else if (accept) begin
                            wr_en  = 1'b1;
                            wptr_d = wptr_q + PW'(1);
                        end
                    end
                    S_VOTE: begin
                        for (int t = 0; t < 8; t++) begin
                            if (hist_q[scan_q] == 3'(t)) cnt_d[t] = cnt_q[t] + CW'(1);
                        end
                        scan_d = scan_q + PW'(1);
                    end
                    S_DECIDE: begin
                        svalid_d = 1'b1;
                        sconf_d  = agree;
                        if (win_cnt >= CW'(VOTE_MIN)) begin
                            locked_d = 1'b1;
                            stype_d  = win_type;
                            tchg_d   = (win_type != stype_q);
                        end else begin
                            locked_d = 1'b0;
                        end
                    end
                    default: ;
                endcase

                if (accept && (state_q == S_VOTE || state_q == S_DECIDE)) begin
                    pend_vld_d  = 1'b1;
                    pend_type_d = waveform_type_in;
                    if (pend_vld_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end
            end

            if (state_d == S_VOTE && state_q != S_VOTE) begin
                cnt_d  = '{default: '0};
                scan_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= 3'd0;
            wptr_q      <= '0;
            fill_q      <= '0;
            scan_q      <= '0;
            cnt_q       <= '{default: '0};
            pend_vld_q  <= 1'b0;
            pend_type_q <= 3'd0;
            stype_q     <= 3'd7;
            sconf_q     <= 8'd0;
            locked_q    <= 1'b0;
            svalid_q    <= 1'b0;
            tchg_q      <= 1'b0;
            drop_q      <= 8'd0;
            tmo_q       <= '0;
        end else begin
            if (!ai_enable) begin
                for (int i = 0; i < DEPTH; i++) hist_q[i] <= 3'd0;
            end else if (wr_en) begin
                hist_q[wptr_q] <= wr_data;
            end
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            scan_q      <= scan_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_type_q <= pend_type_d;
            stype_q     <= stype_d;
            sconf_q     <= sconf_d;
            locked_q    <= locked_d;
            svalid_q    <= svalid_d;
            tchg_q      <= tchg_d;
            drop_q      <= drop_d;
            tmo_q       <= tmo_d;
        end
    end

    assign stable_type       = stype_q;
    assign stable_confidence = sconf_q;
    assign locked            = locked_q;
    assign stable_valid      = svalid_q;
    assign type_changed      = tchg_q;
    assign dropped_cnt       = drop_q;

endmodule

// File: tb/tb_ai_result_stabilizer.sv
// Randomized bench for ai_result_stabilizer against a queue-based history/vote
// model that predicts every output on every cycle.
module tb_ai_result_stabilizer;

    localparam int DEPTH    = 8;
    localparam int VOTE_MIN = 5;
    localparam int CONF_MIN = 128;
    localparam int TMO      = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ai_enable = 1'b0;
    logic [2:0] wtype = 3'd0;
    logic [7:0] conf = 8'd0;
    logic       rvalid = 1'b0;
    logic [2:0] stable_type;
    logic [7:0] stable_confidence;
    logic       locked;
    logic       stable_valid;
    logic       type_changed;
    logic [7:0] dropped_cnt;

    ai_result_stabilizer #(
        .DEPTH(DEPTH), .VOTE_MIN(VOTE_MIN), .CONF_MIN(8'(CONF_MIN)), .TIMEOUT_CYCLES(32'(TMO))
    ) dut (
        .clk(clk), .rst_n(rst_n), .ai_enable(ai_enable),
        .waveform_type_in(wtype), .confidence_in(conf), .result_valid_in(rvalid),
        .stable_type(stable_type), .stable_confidence(stable_confidence),
        .locked(locked), .stable_valid(stable_valid), .type_changed(type_changed),
        .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int hist[$];
    int pend = -1;
    bit vote_active = 0;
    int decide_at = 0;
    int snap[8];
    int cyc = 0;
    int idle_cnt = 0;
    bit in_idle = 1;
    int e_type = 7, e_conf = 0, e_lock = 0, e_sv = 0, e_tc = 0, e_drop = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int ty);
        if (hist.size() == DEPTH) void'(hist.pop_front());
        hist.push_back(ty);
    endtask

    task automatic start_vote();
        for (int t = 0; t < 8; t++) snap[t] = 0;
        foreach (hist[i]) snap[hist[i]]++;
        vote_active = 1;
        decide_at = cyc + DEPTH + 1;
    endtask

    task automatic decide();
        int w;
        int a;
        w = 0;
        for (int t = 1; t < 8; t++) if (snap[t] > snap[w]) w = t;
        a = (snap[w] * 255) / DEPTH;
        if (a > 255) a = 255;
        e_conf = a;
        e_sv = 1;
        if (snap[w] >= VOTE_MIN) begin
            if (w != e_type) e_tc = 1;
            e_type = w;
            e_lock = 1;
        end else begin
            e_lock = 0;
        end
    endtask

    task automatic pend_put(input int ty);
        if (pend >= 0 && e_drop < 255) e_drop++;
        pend = ty;
    endtask

    task automatic model_edge(input bit en, input bit v, input int ty, input int cf);
        bit acc;
        bit fire;
        e_sv = 0;
        e_tc = 0;
        if (!en) begin
            hist.delete();
            pend = -1; vote_active = 0; idle_cnt = 0; in_idle = 1;
            e_type = 7; e_conf = 0; e_lock = 0; e_drop = 0;
            return;
        end
        cyc++;
        acc = v && (cf >= CONF_MIN);
        fire = 0;
        if (v) idle_cnt = 0;
        else if (idle_cnt < TMO) begin
            idle_cnt++;
            fire = (idle_cnt == TMO);
        end
        if (in_idle) begin
            in_idle = 0;
            return;
        end
        if (fire) begin
            hist.delete();
            pend = -1;
            vote_active = 0;
            if (e_type != 7) e_tc = 1;
            e_type = 7;
            e_lock = 0;
            return;
        end
        if (vote_active) begin
            if (cyc == decide_at) begin
                decide();
                vote_active = 0;
            end
            if (acc) pend_put(ty);
        end else if (pend >= 0) begin
            push(pend);
            pend = acc ? ty : -1;
            start_vote();
        end else if (acc) begin
            push(ty);
            if (hist.size() == DEPTH) start_vote();
        end
    endtask

    task automatic cycle(input bit en, input bit v, input int ty, input int cf);
        ai_enable = en;
        rvalid    = v;
        wtype     = ty[2:0];
        conf      = cf[7:0];
        @(posedge clk);
        model_edge(en, v, ty, cf);
        @(negedge clk);
        chk("stable_type", int'(stable_type), e_type);
        chk("stable_confidence", int'(stable_confidence), e_conf);
        chk("locked", int'(locked), e_lock);
        chk("stable_valid", int'(stable_valid), e_sv);
        chk("type_changed", int'(type_changed), e_tc);
        chk("dropped_cnt", int'(dropped_cnt), e_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, $urandom_range(0, 7), $urandom_range(0, 255));
    endtask

    task automatic random_run(input int n, input bit toggle_en);
        int gap;
        bit v;
        bit en;
        gap = 0;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 3) == 0) || (gap >= 60);
            en = !(toggle_en && $urandom_range(0, 49) == 0);
            gap = v ? 0 : gap + 1;
            cycle(en, v, $urandom_range(0, 7), $urandom_range(0, 255));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst stable_type", int'(stable_type), 7);
        chk("rst stable_confidence", int'(stable_confidence), 0);
        chk("rst locked", int'(locked), 0);
        chk("rst stable_valid", int'(stable_valid), 0);
        chk("rst type_changed", int'(type_changed), 0);
        chk("rst dropped_cnt", int'(dropped_cnt), 0);
        rst_n = 1'b1;
        idle(3);

        // Fill and lock
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 2, 200);
            if (i < 7) idle($urandom_range(0, 3));
        end
        idle(12);
        chk("lock type", int'(stable_type), 2);
        chk("lock conf", int'(stable_confidence), 255);
        chk("lock locked", int'(locked), 1);

        // Hysteresis
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, $urandom_range(128, 255));
            idle(12);
        end
        chk("hyst hold type", int'(stable_type), 2);
        chk("hyst hold conf", int'(stable_confidence), 159);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 1, $urandom_range(128, 255));
            idle(12);
        end
        chk("hyst switch type", int'(stable_type), 1);
        chk("hyst switch conf", int'(stable_confidence), 159);

        // Low confidence
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 4, $urandom_range(0, 127));
            idle(2);
        end

        // Tie and unlock
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, (i < 4) ? 0 : 3, 200);
            idle(12);
        end
        chk("tie type held", int'(stable_type), 1);
        chk("tie locked", int'(locked), 0);
        chk("tie conf", int'(stable_confidence), 127);

        // Pending and drop
        cycle(1, 1, 5, 200);
        idle(1);
        cycle(1, 1, 6, 200);
        idle(1);
        cycle(1, 1, 2, 200);
        cycle(1, 1, 6, 250);
        idle(25);
        chk("pend dropped", int'(dropped_cnt), 2);

        random_run(400, 0);

        // Timeout
        idle(TMO + 10);
        chk("tmo type", int'(stable_type), 7);
        chk("tmo locked", int'(locked), 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 3, 220);
        idle(4);

        // Disable mid-vote
        cycle(0, 0, 0, 0);
        chk("dis type", int'(stable_type), 7);
        chk("dis conf", int'(stable_confidence), 0);
        chk("dis locked", int'(locked), 0);
        chk("dis dropped", int'(dropped_cnt), 0);
        idle(15);

        random_run(300, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
